// File: rtl/cv32e40x_xif_aes_ctrl_if.sv
// cv32e40x_xif_aes_ctrl_if: XIF issue/commit/result channels plus saes32 FU link
interface cv32e40x_xif_aes_ctrl_if #(
  parameter int X_ID_WIDTH = 4
);
  logic                  issue_valid;
  logic                  issue_ready;
  logic [31:0]           issue_instr;
  logic [X_ID_WIDTH-1:0] issue_id;
  logic [1:0][31:0]      issue_rs;
  logic [1:0]            issue_rs_valid;
  logic                  issue_accept;
  logic                  issue_writeback;
  logic                  commit_valid;
  logic [X_ID_WIDTH-1:0] commit_id;
  logic                  commit_kill;
  logic                  fu_valid;
  logic [31:0]           fu_rs1;
  logic [31:0]           fu_rs2;
  logic [1:0]            fu_bs;
  logic [3:0]            fu_op;
  logic [31:0]           fu_rd;
  logic                  fu_ready;
  logic                  result_valid;
  logic                  result_ready;
  logic [X_ID_WIDTH-1:0] result_id;
  logic [31:0]           result_data;
  logic [4:0]            result_rd;
  logic                  result_we;
  modport slave (
    input  issue_valid, issue_instr, issue_id, issue_rs, issue_rs_valid,
    input  commit_valid, commit_id, commit_kill, fu_rd, fu_ready, result_ready,
    output issue_ready, issue_accept, issue_writeback, fu_valid, fu_rs1, fu_rs2, fu_bs, fu_op,
    output result_valid, result_id, result_data, result_rd, result_we
  );
  modport master (
    output issue_valid, issue_instr, issue_id, issue_rs, issue_rs_valid,
    output commit_valid, commit_id, commit_kill, fu_rd, fu_ready, result_ready,
    input  issue_ready, issue_accept, issue_writeback, fu_valid, fu_rs1, fu_rs2, fu_bs, fu_op,
    input  result_valid, result_id, result_data, result_rd, result_we
  );
endinterface

// File: rtl/cv32e40x_xif_aes_ctrl.sv
// cv32e40x_xif_aes_ctrl: sequences XIF-issued aes32* instructions one at a time through the saes32 unit
module cv32e40x_xif_aes_ctrl #(
  parameter int X_ID_WIDTH  = 4,
  parameter bit SAES_DEC_EN = 1'b1
) (
  input logic                    clk,
  input logic                    rst_n,
  cv32e40x_xif_aes_ctrl_if.slave xif
);
  typedef enum logic [1:0] {IDLE, WAIT_COMMIT, EXEC, RESULT} state_t;
  state_t                state_q;
  logic [X_ID_WIDTH-1:0] id_q;
  logic [31:0]           rs1_q;
  logic [31:0]           rs2_q;
  logic [31:0]           data_q;
  logic [1:0]            bs_q;
  logic [3:0]            op_q;
  logic [4:0]            rd_q;
  logic [4:0]            funct;
  logic [3:0]            op_dec;
  logic                  is_aes;
  logic                  exec;
  logic                  res;
  always_comb begin
    funct  = xif.issue_instr[29:25];
    op_dec = (xif.issue_instr[6:0] != 7'b0110011 || xif.issue_instr[14:12] != 3'b000) ? 4'b0000 :
             {SAES_DEC_EN && funct == 5'b10111, SAES_DEC_EN && funct == 5'b10101,
              funct == 5'b10011, funct == 5'b10001};
    is_aes = |op_dec;
    xif.issue_ready     = xif.issue_valid && (!is_aes || (state_q == IDLE && xif.issue_rs_valid == 2'b11));
    xif.issue_accept    = xif.issue_ready && is_aes;
    xif.issue_writeback = xif.issue_accept;
    exec = state_q == EXEC;
    res  = state_q == RESULT;
    xif.fu_valid     = exec;
    xif.fu_rs1       = exec ? rs1_q : 32'h0;
    xif.fu_rs2       = exec ? rs2_q : 32'h0;
    xif.fu_bs        = exec ? bs_q : 2'b00;
    xif.fu_op        = exec ? op_q : 4'b0000;
    xif.result_valid = res;
    xif.result_id    = res ? id_q : '0;
    xif.result_data  = res ? data_q : 32'h0;
    xif.result_rd    = res ? rd_q : 5'd0;
    xif.result_we    = res && rd_q != 5'd0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      id_q    <= '0;
      rs1_q   <= 32'h0;
      rs2_q   <= 32'h0;
      data_q  <= 32'h0;
      bs_q    <= 2'b00;
      op_q    <= 4'b0000;
      rd_q    <= 5'd0;
    end else begin
      case (state_q)
        IDLE: if (xif.issue_accept) begin
          id_q    <= xif.issue_id;
          rs1_q   <= xif.issue_rs[0];
          rs2_q   <= xif.issue_rs[1];
          bs_q    <= xif.issue_instr[31:30];
          op_q    <= op_dec;
          rd_q    <= xif.issue_instr[11:7];
          state_q <= !(xif.commit_valid && xif.commit_id == xif.issue_id) ? WAIT_COMMIT :
                     xif.commit_kill ? IDLE : EXEC;
        end
        WAIT_COMMIT: if (xif.commit_valid && xif.commit_id == id_q) state_q <= xif.commit_kill ? IDLE : EXEC;
        EXEC: if (xif.fu_ready) begin
          data_q  <= xif.fu_rd;
          state_q <= RESULT;
        end
        RESULT: if (xif.result_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
